// File: rtl/aq_ifu_ipack_queue_if.sv
// ---------------------------------------------------------------------------
// aq_ifu_ipack_queue_if
//   Bundle of every non-clock/reset signal of the instruction-package queue.
//
//   Handshake semantics (the one place they are written down):
//     - Create: a write of ipack_wr_num halfwords is taken on a rising clock
//       edge when ipack_wr_vld & ipack_wr_rdy are both high. ipack_wr_rdy
//       depends only on the queue occupancy, never on ipack_wr_vld or on the
//       same-cycle retire. If ipack_wr_rdy is low the write is dropped whole,
//       so upstream must hold it and present it again.
//     - Read/retire: ipack_rd_vld[j] marks the j-th oldest entry as present.
//       Decode consumes entries by driving ipack_rd_retire_num; the queue
//       clamps it to the current occupancy, so over-retire is harmless.
//     - ipack_buf_flush wins over create and retire in the same cycle.
//
//   Modports:
//     master - fetch/decode side (drives writes, retire count, flush)
//     slave  - the queue itself
// ---------------------------------------------------------------------------
interface aq_ifu_ipack_queue_if #(
  parameter int DEPTH = 8,
  parameter int WR_W  = 2,
  parameter int RD_W  = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int WN_W  = $clog2(WR_W + 1);
  localparam int RN_W  = $clog2(RD_W + 1);

  // control
  logic                  ipack_buf_flush;
  // create side
  logic                  ipack_wr_vld;
  logic [WN_W-1:0]       ipack_wr_num;
  logic [16*WR_W-1:0]    ipack_wr_inst;
  logic [WR_W-1:0]       ipack_wr_acc_err;
  logic [WR_W-1:0]       ipack_wr_pgflt;
  logic                  ipack_wr_rdy;
  // read / retire side
  logic [RD_W-1:0]       ipack_rd_vld;
  logic [16*RD_W-1:0]    ipack_rd_inst;
  logic [RD_W-1:0]       ipack_rd_acc_err;
  logic [RD_W-1:0]       ipack_rd_pgflt;
  logic [RN_W-1:0]       ipack_rd_retire_num;
  // status
  logic [CNT_W-1:0]      ipack_entry_cnt;
  logic                  ipack_empty;
  logic                  ipack_full;

  modport master (
    output ipack_buf_flush,
    output ipack_wr_vld,
    output ipack_wr_num,
    output ipack_wr_inst,
    output ipack_wr_acc_err,
    output ipack_wr_pgflt,
    input  ipack_wr_rdy,
    input  ipack_rd_vld,
    input  ipack_rd_inst,
    input  ipack_rd_acc_err,
    input  ipack_rd_pgflt,
    output ipack_rd_retire_num,
    input  ipack_entry_cnt,
    input  ipack_empty,
    input  ipack_full
  );

  modport slave (
    input  ipack_buf_flush,
    input  ipack_wr_vld,
    input  ipack_wr_num,
    input  ipack_wr_inst,
    input  ipack_wr_acc_err,
    input  ipack_wr_pgflt,
    output ipack_wr_rdy,
    output ipack_rd_vld,
    output ipack_rd_inst,
    output ipack_rd_acc_err,
    output ipack_rd_pgflt,
    input  ipack_rd_retire_num,
    output ipack_entry_cnt,
    output ipack_empty,
    output ipack_full
  );
endinterface

// File: rtl/aq_ifu_ipack_queue.sv
// ---------------------------------------------------------------------------
// aq_ifu_ipack_queue
//   Circular FIFO of DEPTH halfword instruction-package entries between the
//   IFU fetch-data aligner and the ID stage. Each entry carries inst[15:0],
//   acc_err and pgflt. Up to WR_W halfwords are created per cycle; the oldest
//   RD_W entries are presented to decode, which retires 0..RD_W per cycle.
//
//   Ports:
//     forever_cpuclk  clock
//     cpurst_b        asynchronous reset, active low
//     ipack           aq_ifu_ipack_queue_if.slave: flush, create lanes,
//                     wr_rdy, read ports, retire count, occupancy/empty/full
//
//   Notes:
//     - Occupancy is kept as an explicit counter, so the pointers are plain
//       log2(DEPTH)-bit values that wrap naturally (DEPTH is a power of 2).
//     - Read outputs come straight from the registers: data written this
//       cycle becomes visible next cycle, with no empty-queue bypass.
//     - Each entry has its own write enable and only changes when a create
//       targets it; flush resets pointers/count but leaves storage intact.
// ---------------------------------------------------------------------------
module aq_ifu_ipack_queue #(
  parameter int DEPTH = 8,
  parameter int WR_W  = 2,
  parameter int RD_W  = 2
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  aq_ifu_ipack_queue_if.slave   ipack
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int WN_W  = $clog2(WR_W + 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;

  logic [15:0]       ent_inst    [DEPTH];
  logic [DEPTH-1:0]  ent_acc_err;
  logic [DEPTH-1:0]  ent_pgflt;

  // -------------------------------------------------------------------------
  // Create side
  // -------------------------------------------------------------------------
  logic              wr_rdy;
  logic              wr_fire;
  logic [WN_W-1:0]   wr_acc_num;

  // Room for a full-width write, judged on the occupancy before this edge.
  assign wr_rdy  = (cnt <= CNT_W'(DEPTH - WR_W));

  // Flush suppresses the create entirely, including the storage writes.
  assign wr_fire = ipack.ipack_wr_vld & wr_rdy & ~ipack.ipack_buf_flush;

  // Number of lanes actually created. The lane count field can encode values
  // above WR_W; those are held to WR_W since no further lanes exist.
  always_comb begin
    wr_acc_num = '0;
    if (wr_fire) begin
      if (ipack.ipack_wr_num > WN_W'(WR_W)) begin
        wr_acc_num = WN_W'(WR_W);
      end else begin
        wr_acc_num = ipack.ipack_wr_num;
      end
    end
  end

  // Per-entry write enables and data. Lane i lands at (wr_ptr + i) mod
  // DEPTH, so a create straddling entry DEPTH-1 wraps into entry 0.
  logic [DEPTH-1:0]  ent_we;
  logic [15:0]       ent_wdata_inst [DEPTH];
  logic [DEPTH-1:0]  ent_wdata_acc_err;
  logic [DEPTH-1:0]  ent_wdata_pgflt;
  logic [PTR_W-1:0]  wr_tgt;

  always_comb begin
    ent_we            = '0;
    ent_wdata_acc_err = '0;
    ent_wdata_pgflt   = '0;
    wr_tgt            = '0;
    for (int e = 0; e < DEPTH; e++) begin
      ent_wdata_inst[e] = 16'h0000;
    end
    for (int i = 0; i < WR_W; i++) begin
      if (WN_W'(i) < wr_acc_num) begin
        wr_tgt                    = wr_ptr + PTR_W'(i);
        ent_we[wr_tgt]            = 1'b1;
        ent_wdata_inst[wr_tgt]    = ipack.ipack_wr_inst[16*i +: 16];
        ent_wdata_acc_err[wr_tgt] = ipack.ipack_wr_acc_err[i];
        ent_wdata_pgflt[wr_tgt]   = ipack.ipack_wr_pgflt[i];
      end
    end
  end

  // Entry storage
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      for (int e = 0; e < DEPTH; e++) begin
        ent_inst[e]    <= 16'h0000;
        ent_acc_err[e] <= 1'b0;
        ent_pgflt[e]   <= 1'b0;
      end
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (ent_we[e]) begin
          ent_inst[e]    <= ent_wdata_inst[e];
          ent_acc_err[e] <= ent_wdata_acc_err[e];
          ent_pgflt[e]   <= ent_wdata_pgflt[e];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Retire side
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0]  retire_req;
  logic [CNT_W-1:0]  retire_eff;

  assign retire_req = CNT_W'(ipack.ipack_rd_retire_num);

  // Never retire more than is held, so the count cannot underflow.
  assign retire_eff = (retire_req > cnt) ? cnt : retire_req;

  // -------------------------------------------------------------------------
  // Pointers and occupancy
  // -------------------------------------------------------------------------
  // wr_rdy guarantees cnt + wr_acc_num <= DEPTH, and retire_eff <= cnt, so
  // the update stays within 0..DEPTH.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (ipack.ipack_buf_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(wr_acc_num);
      rd_ptr <= rd_ptr + PTR_W'(retire_eff);
      cnt    <= cnt + CNT_W'(wr_acc_num) - retire_eff;
    end
  end

  // -------------------------------------------------------------------------
  // Read ports
  // -------------------------------------------------------------------------
  // Port j shows the j-th oldest entry. Validity comes from the count alone,
  // and invalid ports are zero-masked so stale storage never leaks out
  // (this is also what hides old entries after a flush).
  logic [RD_W-1:0]    rd_vld;
  logic [16*RD_W-1:0] rd_inst;
  logic [RD_W-1:0]    rd_acc_err;
  logic [RD_W-1:0]    rd_pgflt;
  logic [PTR_W-1:0]   rd_idx;

  always_comb begin
    rd_vld     = '0;
    rd_inst    = '0;
    rd_acc_err = '0;
    rd_pgflt   = '0;
    rd_idx     = '0;
    for (int j = 0; j < RD_W; j++) begin
      rd_idx = rd_ptr + PTR_W'(j);
      if (CNT_W'(j) < cnt) begin
        rd_vld[j]             = 1'b1;
        rd_inst[16*j +: 16]   = ent_inst[rd_idx];
        rd_acc_err[j]         = ent_acc_err[rd_idx];
        rd_pgflt[j]           = ent_pgflt[rd_idx];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign ipack.ipack_wr_rdy     = wr_rdy;
  assign ipack.ipack_rd_vld     = rd_vld;
  assign ipack.ipack_rd_inst    = rd_inst;
  assign ipack.ipack_rd_acc_err = rd_acc_err;
  assign ipack.ipack_rd_pgflt   = rd_pgflt;
  assign ipack.ipack_entry_cnt  = cnt;
  assign ipack.ipack_empty      = (cnt == '0);
  assign ipack.ipack_full       = (cnt == CNT_W'(DEPTH));

endmodule
